// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start, D[0]..D[3] LSB-first, parity, stop.
// Each bit is held for CLKS_PER_BIT clocks; the line idles high.
module parity_frame_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int ODD_PARITY   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx_out,
    output logic       busy,
    output logic       frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [1:0]       bit_idx;
    logic [3:0]       shift_reg;
    logic             parity_bit;
    logic             bit_end;

    function automatic logic parity_of(input logic [3:0] w);
        return (ODD_PARITY != 0) ? ~^w : ^w;
    endfunction

    assign bit_end   = (bit_cnt == CNT_MAX);
    assign ready_out = (state == IDLE);

    // tx_out, busy and frame_done are set one edge early so they line up
    // with the state they describe instead of lagging it by a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                    if (valid_in) begin
                        shift_reg  <= data_in;
                        parity_bit <= parity_of(data_in);
                        bit_cnt    <= '0;
                        bit_idx    <= '0;
                        tx_out     <= 1'b0;
                        busy       <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        tx_out  <= shift_reg[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt   <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == 2'd3) begin
                            tx_out <= parity_bit;
                            state  <= PARITY;
                        end else begin
                            bit_idx <= bit_idx + 2'd1;
                            tx_out  <= shift_reg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        bit_cnt    <= '0;
                        tx_out     <= 1'b1;
                        frame_done <= (CNT_MAX == '0);
                        state      <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    tx_out <= 1'b1;
                    if (bit_end) begin
                        bit_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        bit_cnt    <= bit_cnt + CNT_W'(1);
                        frame_done <= ((bit_cnt + CNT_W'(1)) == CNT_MAX);
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: three configurations (4 clk/bit even, 4 clk/bit odd,
// 1 clk/bit even) checked cycle by cycle against a frame-level reference model.
module tb_parity_frame_tx;

    localparam int CPB [3] = '{4, 4, 1};
    localparam bit ODD [3] = '{1'b0, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_r [3];
    logic [3:0] data_r  [3];
    logic       tx_w    [3];
    logic       rdy_w   [3];
    logic       busy_w  [3];
    logic       fd_w    [3];

    int checks = 0;
    int failures = 0;
    int exp_frames [3] = '{0, 0, 0};
    int fd_seen    [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    parity_frame_tx #(.CLKS_PER_BIT(4), .ODD_PARITY(0)) u_even4 (
        .clk(clk), .rst(rst), .data_in(data_r[0]), .valid_in(valid_r[0]),
        .ready_out(rdy_w[0]), .tx_out(tx_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));
    parity_frame_tx #(.CLKS_PER_BIT(4), .ODD_PARITY(1)) u_odd4 (
        .clk(clk), .rst(rst), .data_in(data_r[1]), .valid_in(valid_r[1]),
        .ready_out(rdy_w[1]), .tx_out(tx_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));
    parity_frame_tx #(.CLKS_PER_BIT(1), .ODD_PARITY(0)) u_even1 (
        .clk(clk), .rst(rst), .data_in(data_r[2]), .valid_in(valid_r[2]),
        .ready_out(rdy_w[2]), .tx_out(tx_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]));

    always @(negedge clk) begin
        for (int j = 0; j < 3; j++)
            if (fd_w[j] === 1'b1) fd_seen[j]++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    // Line-level frame: bit 0 start, bits 1..4 data LSB-first, bit 5 parity, bit 6 stop.
    function automatic logic [6:0] frame_bits(input logic [3:0] w, input bit odd);
        int ones;
        logic [6:0] f;
        ones = 0;
        for (int b = 0; b < 4; b++) ones += int'(w[b]);
        f[0]   = 1'b0;
        f[4:1] = w;
        f[5]   = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
        f[6]   = 1'b1;
        return f;
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int i);
        chk({tag, "_tx"}, i, 32'(tx_w[i]), 32'd1);
        chk({tag, "_ready"}, i, 32'(rdy_w[i]), 32'd1);
        chk({tag, "_busy"}, i, 32'(busy_w[i]), 32'd0);
        chk({tag, "_done"}, i, 32'(fd_w[i]), 32'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the idle
    // cycle following the frame. hold keeps valid_in high for a back-to-back frame.
    task automatic run_frame(input int i, input logic [3:0] w, input bit hold);
        logic [6:0] bits;
        int c, n;
        c = CPB[i];
        n = 7 * c;
        bits = frame_bits(w, ODD[i]);
        data_r[i]  = w;
        valid_r[i] = 1'b1;
        chk("ready_pre", i, 32'(rdy_w[i]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        for (int t = 0; t < n; t++) begin
            chk("tx_bit", i, 32'(tx_w[i]), 32'(bits[t / c]));
            chk("busy_frame", i, 32'(busy_w[i]), 32'd1);
            chk("ready_frame", i, 32'(rdy_w[i]), 32'd0);
            chk("frame_done", i, 32'(fd_w[i]), 32'(t == n - 1));
            data_r[i]  = 4'($urandom);
            valid_r[i] = hold ? 1'b1 : 1'($urandom);
            if (t == n - 1) valid_r[i] = hold;
            @(negedge clk);
        end
        exp_frames[i]++;
        chk_idle("gap", i);
    endtask

    initial begin
        int k;
        int sel;
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            valid_r[j] = 1'b0;
            data_r[j]  = 4'h0;
        end
        repeat (3) @(negedge clk);
        for (int j = 0; j < 3; j++) chk_idle("reset", j);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk_idle("idle20", 0);
        end

        run_frame(0, 4'b1011, 1'b0);
        run_frame(1, 4'b1011, 1'b0);
        run_frame(1, 4'b0000, 1'b0);
        run_frame(0, 4'hA, 1'b1);
        run_frame(0, 4'h5, 1'b0);
        run_frame(2, 4'b0110, 1'b0);

        // Reset during DATA of a 4'hF frame.
        data_r[0]  = 4'hF;
        valid_r[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_r[0] = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_pre_tx", 0, 32'(tx_w[0]), 32'd1);
        chk("abort_pre_busy", 0, 32'(busy_w[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("async_rst", 0);
        valid_r[0] = 1'b1;
        data_r[0]  = 4'h9;
        repeat (2) begin
            @(negedge clk);
            chk_idle("in_rst", 0);
        end
        valid_r[0] = 1'b0;
        rst = 1'b0;
        run_frame(0, 4'h3, 1'b0);

        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 2);
            k = $urandom_range(1, 3);
            for (int m = 0; m < k; m++)
                run_frame(sel, 4'($urandom), m != k - 1);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk_idle("rand_idle", sel);
            end
        end

        repeat (2) @(negedge clk);
        for (int j = 0; j < 3; j++)
            chk("done_count", j, 32'(fd_seen[j]), 32'(exp_frames[j]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parity_frame_tx.md
# parity_frame_tx

Serial frame transmitter that consumes a 4-bit data word, computes its parity bit, and shifts out a 7-bit frame on a single line. The frame is start bit, then D[0]..D[3] LSB-first, then parity, then stop. The block sits directly downstream of the 4-bit parity generation stage and turns each word plus parity into a line-level serial frame. Each bit is held for a programmable number of clock cycles.

## Interface

Parameters:
- CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 1..255.
- ODD_PARITY, default 0: 0 selects even parity, 1 selects odd parity.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  4  data word to send; sampled only on acceptance.
- valid_in  input  1  upstream has a word on data_in.
- ready_out  output  1  block can accept a word this cycle.
- tx_out  output  1  serial line; idles high.
- busy  output  1  a frame is in progress (any state other than IDLE).
- frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

## Operation

- States: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - tx_out=1, ready_out=1, busy=0.
  - Acceptance is valid_in && ready_out at a rising edge. On acceptance:
    - data_in is latched into a 4-bit shift register.
    - The parity bit is latched as ^data_in if ODD_PARITY=0, or ~^data_in if ODD_PARITY=1.
    - The bit-cycle counter clears to 0 and the state moves to START.
- **START**: tx_out=0 for CLKS_PER_BIT cycles, then DATA with the bit index at 0.
- **DATA**
  - tx_out = shift register bit 0.
  - After CLKS_PER_BIT cycles the register shifts right and the bit index increments.
  - After bit index 3 completes, the state moves to PARITY.
- **PARITY**: tx_out = latched parity bit for CLKS_PER_BIT cycles, then STOP.
- **STOP**
  - tx_out=1 for CLKS_PER_BIT cycles.
  - frame_done=1 on the final cycle, then the state returns to IDLE.
- ready_out = (state==IDLE). valid_in and data_in are ignored in every non-IDLE state, so changes during a frame have no effect.
- Bit-cycle counter: width clog2(CLKS_PER_BIT)+1. It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- With CLKS_PER_BIT=1, every bit lasts exactly one cycle.
- tx_out, busy and frame_done are registered outputs with no combinational path from inputs. ready_out is decoded from the state register only.

## Timing

- Reset values: state=IDLE, tx_out=1, busy=0, frame_done=0, ready_out=1, counters=0, shift register=0, parity=0.
- While rst is high, no acceptance occurs.
- Reset asserted mid-frame:
  - All outputs return to reset values immediately, since the reset is asynchronous.
  - The partial frame is abandoned and tx_out goes high.
  - The first acceptance is possible on the first rising edge after rst deasserts.
- Latency: acceptance at edge k puts tx_out=0 in the cycle following edge k.
- Frame length: exactly 7*CLKS_PER_BIT cycles from the start-bit falling edge to the end of the stop bit.
- Back-to-back frames:
  - The state re-enters IDLE on the edge that ends STOP.
  - ready_out=1 for at least one cycle, with tx_out=1.
  - With valid_in held high, the next start bit begins 7*CLKS_PER_BIT+1 cycles after the previous one.
- frame_done is high for exactly one cycle per completed frame. It is never asserted for a frame aborted by reset.

## Test plan

- Reset, CLKS_PER_BIT=4, valid_in=0 -> tx_out=1, ready_out=1, busy=0, frame_done=0 for 20 cycles.
- Even parity, data_in=4'b1011 -> tx_out sequence 0,1,1,0,1,1,1 (start, D0..D3, parity=1, stop), each bit 4 cycles. ready_out=0 for 28 cycles, then one frame_done pulse.
- ODD_PARITY=1, data_in=4'b1011 -> parity bit 0. Then data_in=4'b0000 -> parity bit 1. Frames are 0,1,1,0,1,0,1 and 0,0,0,0,0,1,1.
- valid_in held high, data_in=4'hA then 4'h5 -> two frames with exactly one idle-high cycle between them. data_in toggled mid-frame does not alter the bits on tx_out.
- rst pulsed during the DATA state of a 4'hF frame -> tx_out=1 and busy=0 asynchronously, no frame_done. The next accepted word 4'h3 transmits a clean frame 0,1,1,0,0,0,1.
- CLKS_PER_BIT=1, data_in=4'b0110 even -> seven single-cycle bits 0,0,1,1,0,0,1, and frame_done on the 7th.
